// File: rtl/key_pkg.sv
// Shared types and default sizing for the key event path.
package key_pkg;

   localparam int unsigned NUM_KEYS_DEF = 4;
   localparam int unsigned GAP_W_DEF    = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } arb_state_e;

endpackage : key_pkg

// File: rtl/key_event_arbiter_rr_arbiter.sv
// Rotating-priority selector: first requester strictly after 'last', with wrap.
module key_event_arbiter_rr_arbiter #(
   parameter int unsigned NUM_KEYS = 4,
   parameter int unsigned IDX_W    = 2
) (
   input  logic [NUM_KEYS-1:0] req_i,
   input  logic [IDX_W-1:0]    last_i,
   output logic [IDX_W-1:0]    gnt_idx_c,
   output logic                any_c
);

   // Walk from the farthest offset to the nearest so the nearest requester wins.
   always_comb begin
      int unsigned pos;
      pos       = 0;
      gnt_idx_c = '0;
      any_c     = |req_i;
      for (int unsigned k = NUM_KEYS; k > 0; k--) begin
         pos = (32'(last_i) + k) % NUM_KEYS;
         if (req_i[pos]) begin
            gnt_idx_c = IDX_W'(pos);
         end
      end
   end

endmodule : key_event_arbiter_rr_arbiter

// File: rtl/key_event_arbiter.sv
// Latches key press pulses as pending events and hands them round-robin to a
// single consumer over valid/ready, with an optional idle gap between events.
module key_event_arbiter
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned GAP_W      = GAP_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_KEYS-1:0]         key_come,
   input  logic [NUM_KEYS-1:0]         key_en,
   output logic                        evt_valid,
   output logic [$clog2(NUM_KEYS)-1:0] evt_idx,
   input  logic                        evt_ready,
   output logic [NUM_KEYS-1:0]         overrun,
   input  logic                        ovr_clr
);

   localparam int unsigned IDX_W = $clog2(NUM_KEYS);

   arb_state_e          state_q, state_d;
   logic                valid_q, valid_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [NUM_KEYS-1:0] pending_q, pending_d;
   logic [NUM_KEYS-1:0] ovr_q, ovr_d;
   logic [NUM_KEYS-1:0] grant_c;
   logic [IDX_W-1:0]    sel_idx_c;
   logic                sel_any_c;

   key_event_arbiter_rr_arbiter #(
      .NUM_KEYS (NUM_KEYS),
      .IDX_W    (IDX_W)
   ) u_rr (
      .req_i     (pending_q & key_en),
      .last_i    (last_q),
      .gnt_idx_c (sel_idx_c),
      .any_c     (sel_any_c)
   );

   // State, presented event, rotation pointer, gap counter and event flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         last_q    <= IDX_W'(NUM_KEYS - 1);
         gap_q     <= '0;
         pending_q <= '0;
         ovr_q     <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         gap_q     <= gap_d;
         pending_q <= pending_d;
         ovr_q     <= ovr_d;
      end
   end

   // Next-state: grant from IDLE, hold until handshake, then optional gap.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      last_d  = last_q;
      gap_d   = gap_q;
      grant_c = '0;
      case (state_q)
         IDLE: begin
            if (sel_any_c) begin
               idx_d   = sel_idx_c;
               last_d  = sel_idx_c;
               grant_c = NUM_KEYS'(1) << sel_idx_c;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (evt_ready) begin
               valid_d = 1'b0;
               if (GAP_CYCLES > 0) begin
                  gap_d   = GAP_W'(GAP_CYCLES - 1);
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Per-key pending latch and sticky overrun; a new overrun beats ovr_clr.
   always_comb begin
      pending_d = pending_q;
      ovr_d     = ovr_clr ? '0 : ovr_q;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (!key_en[i]) begin
            pending_d[i] = 1'b0;
         end else if (grant_c[i]) begin
            pending_d[i] = key_come[i];
         end else if (key_come[i]) begin
            pending_d[i] = 1'b1;
            if (pending_q[i]) begin
               ovr_d[i] = 1'b1;
            end
         end
      end
   end

   assign evt_valid = valid_q;
   assign evt_idx   = idx_q;
   assign overrun   = ovr_q;

endmodule : key_event_arbiter

// File: tb/tb_key_event_arbiter.sv
// Directed checks for key_event_arbiter: one DUT without gap, one with a 10-cycle gap.
module tb_key_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_come;
   logic [3:0] key_en;
   logic       evt_ready;
   logic       ovr_clr;

   logic       v0, vg;
   logic [1:0] i0, ig;
   logic [3:0] o0, og;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   key_event_arbiter #(.NUM_KEYS(4), .GAP_CYCLES(0), .GAP_W(16)) dut (
      .clk(clk), .rst(rst), .key_come(key_come), .key_en(key_en),
      .evt_valid(v0), .evt_idx(i0), .evt_ready(evt_ready),
      .overrun(o0), .ovr_clr(ovr_clr)
   );

   key_event_arbiter #(.NUM_KEYS(4), .GAP_CYCLES(10), .GAP_W(16)) dut_gap (
      .clk(clk), .rst(rst), .key_come(key_come), .key_en(key_en),
      .evt_valid(vg), .evt_idx(ig), .evt_ready(evt_ready),
      .overrun(og), .ovr_clr(ovr_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [3:0] k);
      key_come = k;
      step();
      key_come = 4'b0000;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      key_come  = 4'b0000;
      key_en    = 4'b1111;
      evt_ready = 1'b1;
      ovr_clr   = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key_come = 4'b0000; key_en = 4'b1111; evt_ready = 1'b0; ovr_clr = 1'b0;
      step();
      total++;
      if (v0 !== 1'b0 || i0 !== 2'd0 || o0 !== 4'b0000 || vg !== 1'b0) begin
         $display("FAIL reset: valid=%b idx=%0d ovr=%b gvalid=%b, want 0/0/0000/0", v0, i0, o0, vg);
      end else passed++;
   endtask

   task automatic test_single();
      do_reset();
      pulse(4'b0100);                  // now t+1
      total++;
      if (v0 !== 1'b0) $display("FAIL single_t1: valid=%b want 0", v0); else passed++;
      step();                          // t+2
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd2) $display("FAIL single_t2: valid=%b idx=%0d want 1/2", v0, i0);
      else passed++;
      step();                          // t+3
      total++;
      if (v0 !== 1'b0 || o0 !== 4'b0000) $display("FAIL single_t3: valid=%b ovr=%b want 0/0000", v0, o0);
      else passed++;
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_idx [3];
      exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd3;
      do_reset();
      pulse(4'b1011);                  // t+1
      for (int e = 0; e < 3; e++) begin
         step();                       // t+2, t+4, t+6
         total++;
         if (v0 !== 1'b1 || i0 !== exp_idx[e])
            $display("FAIL simul_evt%0d: valid=%b idx=%0d want 1/%0d", e, v0, i0, exp_idx[e]);
         else passed++;
         step();
         total++;
         if (v0 !== 1'b0) $display("FAIL simul_gap%0d: valid=%b want 0", e, v0); else passed++;
      end
      pulse(4'b0001);
      step();
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd0) $display("FAIL simul_wrap: valid=%b idx=%0d want 1/0", v0, i0);
      else passed++;
   endtask

   task automatic test_backpressure();
      int cnt;
      logic bad_idx;
      do_reset();
      evt_ready = 1'b0;
      pulse(4'b0010);                  // t+1
      step();                          // t+2
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd1) $display("FAIL bp_present: valid=%b idx=%0d want 1/1", v0, i0);
      else passed++;
      step(); step(); step();          // t+5
      pulse(4'b0010);                  // t+6
      total++;
      if (o0 !== 4'b0000) $display("FAIL bp_no_ovr: ovr=%b want 0000", o0); else passed++;
      step(); step();                  // t+8
      pulse(4'b0010);                  // t+9
      total++;
      if (o0 !== 4'b0010 || v0 !== 1'b1 || i0 !== 2'd1)
         $display("FAIL bp_ovr: ovr=%b valid=%b idx=%0d want 0010/1/1", o0, v0, i0);
      else passed++;
      evt_ready = 1'b1;
      cnt = 0; bad_idx = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (v0) begin
            cnt++;
            if (i0 !== 2'd1) bad_idx = 1'b1;
         end
         step();
      end
      total++;
      if (cnt != 2 || bad_idx) $display("FAIL bp_drain: events=%0d badidx=%b want 2/0", cnt, bad_idx);
      else passed++;
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      total++;
      if (o0 !== 4'b0000) $display("FAIL bp_clr: ovr=%b want 0000", o0); else passed++;
   endtask

   task automatic test_gap();
      logic seen;
      do_reset();
      pulse(4'b0101);                  // t+1
      step();                          // t+2
      total++;
      if (vg !== 1'b1 || ig !== 2'd0) $display("FAIL gap_first: valid=%b idx=%0d want 1/0", vg, ig);
      else passed++;
      seen = 1'b0;
      for (int c = 3; c <= 13; c++) begin
         step();
         if (vg) seen = 1'b1;
      end
      total++;
      if (seen) $display("FAIL gap_quiet: valid seen during gap=%b want 0", seen); else passed++;
      step();                          // t+14
      total++;
      if (vg !== 1'b1 || ig !== 2'd2) $display("FAIL gap_second: valid=%b idx=%0d want 1/2", vg, ig);
      else passed++;
   endtask

   task automatic test_mask();
      int cnt;
      do_reset();
      key_en = 4'b1110;
      pulse(4'b0001);
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (v0) cnt++;
         step();
      end
      total++;
      if (cnt != 0) $display("FAIL mask_key0: events=%0d want 0", cnt); else passed++;
      key_en = 4'b1111;
      evt_ready = 1'b0;
      pulse(4'b0010);
      step();                          // key 1 presented and held
      pulse(4'b1000);                  // key 3 pending
      key_en = 4'b0100;                // drops key 3 and masks presented key 1
      step();
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd1) $display("FAIL mask_hold: valid=%b idx=%0d want 1/1", v0, i0);
      else passed++;
      key_en = 4'b1111;
      evt_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (v0) cnt++;
         step();
      end
      total++;
      if (cnt != 1 || o0 !== 4'b0000) $display("FAIL mask_drop: events=%0d ovr=%b want 1/0000", cnt, o0);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int cnt;
      do_reset();
      evt_ready = 1'b0;
      pulse(4'b0111);
      step();
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd0) $display("FAIL rmid_pre: valid=%b idx=%0d want 1/0", v0, i0);
      else passed++;
      rst = 1'b1;
      #1;
      total++;
      if (v0 !== 1'b0 || i0 !== 2'd0 || o0 !== 4'b0000)
         $display("FAIL rmid_async: valid=%b idx=%0d ovr=%b want 0/0/0000", v0, i0, o0);
      else passed++;
      step();
      rst = 1'b0;
      evt_ready = 1'b1;
      step();
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (v0) cnt++;
         step();
      end
      total++;
      if (cnt != 0) $display("FAIL rmid_flushed: events=%0d want 0", cnt); else passed++;
      pulse(4'b1000);                  // t+1
      total++;
      if (v0 !== 1'b0) $display("FAIL rmid_t1: valid=%b want 0", v0); else passed++;
      step();                          // t+2
      total++;
      if (v0 !== 1'b1 || i0 !== 2'd3) $display("FAIL rmid_t2: valid=%b idx=%0d want 1/3", v0, i0);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_gap();
      test_mask();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_key_event_arbiter
